// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-requester RAM port arbiter.
package ram_arb_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_LDR = 1'b1;

endpackage

// File: rtl/ram_port_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie the requester that did not win last time gets the grant.
module rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] grant_o
);

    assign grant_o[0] = req_i[0] & (~req_i[1] | last_i);
    assign grant_o[1] = req_i[1] & (~req_i[0] | ~last_i);

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates one synchronous RAM between a CPU and a loader port, with optional
// lock for read-modify-write and a one-deep read tag for routing returned data.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic                  lock0,
    input  logic                  lock1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] ram_read_address,
    output logic [ADDR_WIDTH-1:0] ram_write_address,
    output logic                  ram_write,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    arb_state_e            state_q;
    logic                  last_q;
    logic                  owner_q;
    logic                  rd_pend_q;
    logic                  rd_id_q;
    logic [ADDR_WIDTH-1:0] raddr_q;

    logic [1:0]            rr_gnt;
    logic [1:0]            gnt;
    logic                  any_gnt;
    logic                  gnt_id;
    logic                  gnt_we;
    logic                  gnt_lock;
    logic [ADDR_WIDTH-1:0] gnt_addr;
    logic [DATA_WIDTH-1:0] gnt_wdata;
    logic                  rd_gnt;
    logic                  wr_gnt;

    rr_pick2 u_pick (
        .req_i   ({req1, req0}),
        .last_i  (last_q),
        .grant_o (rr_gnt)
    );

    // While locked only the owner can be granted; nothing is granted in reset.
    always_comb begin
        gnt = 2'b00;
        if (reset_n) begin
            if (state_q == ARB) begin
                gnt = rr_gnt;
            end else if (owner_q == REQ_LDR) begin
                gnt = {req1, 1'b0};
            end else begin
                gnt = {1'b0, req0};
            end
        end
    end

    assign any_gnt   = |gnt;
    assign gnt_id    = gnt[1];
    assign gnt_we    = gnt_id ? we1    : we0;
    assign gnt_lock  = gnt_id ? lock1  : lock0;
    assign gnt_addr  = gnt_id ? addr1  : addr0;
    assign gnt_wdata = gnt_id ? wdata1 : wdata0;
    assign rd_gnt    = any_gnt & ~gnt_we;
    assign wr_gnt    = any_gnt & gnt_we;

    assign gnt0 = gnt[0];
    assign gnt1 = gnt[1];

    assign ram_write         = wr_gnt;
    assign ram_write_address = wr_gnt ? gnt_addr  : '0;
    assign ram_din           = wr_gnt ? gnt_wdata : '0;
    // Hold the previous read address when idle so the RAM address bus stays quiet.
    assign ram_read_address  = rd_gnt ? gnt_addr  : raddr_q;

    assign rvalid0 = rd_pend_q & (rd_id_q == REQ_CPU);
    assign rvalid1 = rd_pend_q & (rd_id_q == REQ_LDR);
    assign rdata   = ram_dout;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ARB;
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            rd_pend_q <= 1'b0;
            rd_id_q   <= 1'b0;
            raddr_q   <= '0;
        end else begin
            rd_pend_q <= rd_gnt;
            if (rd_gnt) begin
                rd_id_q <= gnt_id;
                raddr_q <= gnt_addr;
            end
            if (any_gnt) begin
                last_q <= gnt_id;
                if (gnt_lock) begin
                    state_q <= LOCKED;
                    owner_q <= gnt_id;
                end else begin
                    state_q <= ARB;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural synchronous RAM.
module tb_ram_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req0, req1, we0, we1, lock0, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1, ram_write;
    logic [DW-1:0] rdata, ram_din, ram_dout;
    logic [AW-1:0] ram_read_address, ram_write_address;

    logic [DW-1:0] mem [16];
    bit            mem_init = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .req0              (req0),
        .req1              (req1),
        .we0               (we0),
        .we1               (we1),
        .lock0             (lock0),
        .lock1             (lock1),
        .addr0             (addr0),
        .addr1             (addr1),
        .wdata0            (wdata0),
        .wdata1            (wdata1),
        .gnt0              (gnt0),
        .gnt1              (gnt1),
        .rvalid0           (rvalid0),
        .rvalid1           (rvalid1),
        .rdata             (rdata),
        .ram_read_address  (ram_read_address),
        .ram_write_address (ram_write_address),
        .ram_write         (ram_write),
        .ram_din           (ram_din),
        .ram_dout          (ram_dout)
    );

    // Synchronous RAM: registered read, write commits at the edge.
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'hA000_0000 | i;
            mem_init <= 1'b1;
            ram_dout <= '0;
        end else begin
            if (ram_write) mem[ram_write_address] <= ram_din;
            ram_dout <= mem[ram_read_address];
        end
    end

    typedef struct {
        logic          r0, r1, w0, w1, l0, l1;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        logic          g0, g1, v0, v1, wr;
        logic [AW-1:0] ra;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [DW-1:0] rd;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(
        input logic r0, w0, l0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
        input logic r1, w1, l1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
        input logic g0, g1, v0, v1, wr, input logic [AW-1:0] ra,
        input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic [DW-1:0] rd);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.l1 = l1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1; v.wr = wr;
        v.ra = ra; v.wa = wa; v.wd = wd; v.rd = rd;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        req0 = v.r0; we0 = v.w0; lock0 = v.l0; addr0 = v.a0; wdata0 = v.d0;
        req1 = v.r1; we1 = v.w1; lock1 = v.l1; addr1 = v.a1; wdata1 = v.d1;
    endtask

    task automatic idle();
        req0 = 0; we0 = 0; lock0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; lock1 = 0; addr1 = 0; wdata1 = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " gnt0"}, gnt0, 0);
        chk({tag, " gnt1"}, gnt1, 0);
        chk({tag, " ram_write"}, ram_write, 0);
        chk({tag, " rvalid0"}, rvalid0, 0);
        chk({tag, " rvalid1"}, rvalid1, 0);
        chk({tag, " ram_read_address"}, ram_read_address, 0);
        chk({tag, " ram_write_address"}, ram_write_address, 0);
        chk({tag, " ram_din"}, ram_din, 0);
    endtask

    initial begin
        // Contention (rows 0-4), write-then-read (5-7), lock RMW (8-10), idle lock (11-17).
        //            r0 w0 l0 a0  d0             r1 w1 l1 a1  d1              g0 g1 v0 v1 wr ra  wa  wd             rd
        tbl[0]  = mk(1, 0, 0, 3, 0,              1, 0, 0, 5, 0,               1, 0, 0, 0, 0, 3, 0, 0,             0);
        tbl[1]  = mk(1, 0, 0, 3, 0,              1, 0, 0, 5, 0,               0, 1, 1, 0, 0, 5, 0, 0,             32'hA000_0003);
        tbl[2]  = mk(1, 0, 0, 3, 0,              1, 0, 0, 5, 0,               1, 0, 0, 1, 0, 3, 0, 0,             32'hA000_0005);
        tbl[3]  = mk(1, 0, 0, 3, 0,              1, 0, 0, 5, 0,               0, 1, 1, 0, 0, 5, 0, 0,             32'hA000_0003);
        tbl[4]  = mk(0, 0, 0, 0, 0,              0, 0, 0, 0, 0,               0, 0, 0, 1, 0, 5, 0, 0,             32'hA000_0005);
        tbl[5]  = mk(0, 0, 0, 0, 0,              1, 1, 0, 7, 32'hDEAD_BEEF,   0, 1, 0, 0, 1, 5, 7, 32'hDEAD_BEEF, 0);
        tbl[6]  = mk(1, 0, 0, 7, 0,              0, 0, 0, 0, 0,               1, 0, 0, 0, 0, 7, 0, 0,             0);
        tbl[7]  = mk(0, 0, 0, 0, 0,              1, 0, 0, 9, 0,               0, 1, 1, 0, 0, 9, 0, 0,             32'hDEAD_BEEF);
        tbl[8]  = mk(1, 0, 1, 2, 0,              1, 0, 0, 9, 0,               1, 0, 0, 1, 0, 2, 0, 0,             32'hA000_0009);
        tbl[9]  = mk(1, 1, 0, 2, 32'h1234_5678,  1, 0, 0, 9, 0,               1, 0, 1, 0, 1, 2, 2, 32'h1234_5678, 32'hA000_0002);
        tbl[10] = mk(0, 0, 0, 0, 0,              1, 0, 0, 9, 0,               0, 1, 0, 0, 0, 9, 0, 0,             0);
        tbl[11] = mk(0, 0, 0, 0, 0,              1, 0, 1, 2, 0,               0, 1, 0, 1, 0, 2, 0, 0,             32'hA000_0009);
        tbl[12] = mk(1, 0, 0, 4, 0,              0, 0, 0, 0, 0,               0, 0, 0, 1, 0, 2, 0, 0,             32'h1234_5678);
        tbl[13] = mk(1, 0, 0, 4, 0,              0, 0, 0, 0, 0,               0, 0, 0, 0, 0, 2, 0, 0,             0);
        tbl[14] = mk(1, 0, 0, 4, 0,              0, 0, 0, 0, 0,               0, 0, 0, 0, 0, 2, 0, 0,             0);
        tbl[15] = mk(1, 0, 0, 4, 0,              1, 0, 0, 6, 0,               0, 1, 0, 0, 0, 6, 0, 0,             0);
        tbl[16] = mk(1, 0, 0, 4, 0,              0, 0, 0, 0, 0,               1, 0, 0, 1, 0, 4, 0, 0,             32'hA000_0006);
        tbl[17] = mk(0, 0, 0, 0, 0,              0, 0, 0, 0, 0,               0, 0, 1, 0, 0, 4, 0, 0,             32'hA000_0004);

        // Reset held with both requesters asking.
        idle();
        reset_n = 1'b0;
        req0 = 1; req1 = 1; addr0 = 3; addr1 = 5;
        repeat (3) @(posedge clk);
        #4;
        chk_reset_outputs("reset");
        idle();
        @(posedge clk); #1;
        reset_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            @(posedge clk); #1;
            drive(tbl[i]);
            #3;
            chk($sformatf("row%0d gnt0", i), gnt0, tbl[i].g0);
            chk($sformatf("row%0d gnt1", i), gnt1, tbl[i].g1);
            chk($sformatf("row%0d rvalid0", i), rvalid0, tbl[i].v0);
            chk($sformatf("row%0d rvalid1", i), rvalid1, tbl[i].v1);
            chk($sformatf("row%0d ram_write", i), ram_write, tbl[i].wr);
            chk($sformatf("row%0d ram_read_address", i), ram_read_address, tbl[i].ra);
            if (tbl[i].wr) begin
                chk($sformatf("row%0d ram_write_address", i), ram_write_address, tbl[i].wa);
                chk($sformatf("row%0d ram_din", i), ram_din, tbl[i].wd);
            end
            if (tbl[i].v0 || tbl[i].v1)
                chk($sformatf("row%0d rdata", i), rdata, tbl[i].rd);
        end

        // Reset during the cycle of a read grant: the response must never appear.
        @(posedge clk); #1;
        idle();
        req1 = 1; addr1 = 5;
        #3;
        chk("midrd gnt1", gnt1, 1);
        chk("midrd ram_read_address", ram_read_address, 5);
        #1;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("midrd async");
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #4;
            chk($sformatf("midrd cyc%0d rvalid0", c), rvalid0, 0);
            chk($sformatf("midrd cyc%0d rvalid1", c), rvalid1, 0);
        end

        // After release, a tie goes to requester 0 again.
        @(posedge clk); #1;
        reset_n = 1'b1;
        req0 = 1; addr0 = 3; req1 = 1; addr1 = 5;
        #3;
        chk("post gnt0", gnt0, 1);
        chk("post gnt1", gnt1, 0);
        chk("post rvalid1", rvalid1, 0);
        @(posedge clk); #1;
        idle();
        #3;
        chk("post rvalid0", rvalid0, 1);
        chk("post rvalid1b", rvalid1, 0);
        chk("post rdata", rdata, 32'hA000_0003);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
